vga_line_buffer: RTL and testbench
==================================

VGA_LINE_BUFFER -- requirements
Module: vga_line_buffer

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter PIX_W, default 3, meaning bits per pixel.
REQ-003 SHALL have port clk25MHz  input  1  pixel clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port line_start  input  1  single-cycle pulse from the timing stage, issued during horizontal blanking, at least 1 cycle before the first active pixel of a visible line.
REQ-006 SHALL have port pix_active  input  1  high during each of the LINE_W active pixel cycles of a visible line.
REQ-007 SHALL have port wr_valid  input  1  producer pixel valid.
REQ-008 SHALL have port wr_data  input  PIX_W  producer pixel, in left-to-right order.
REQ-009 SHALL have port wr_ready  output  1  buffer can accept a pixel.
REQ-010 SHALL have port rgb  output  PIX_W  registered pixel to the display driver.
REQ-011 SHALL have port underrun  output  1  sticky flag, set when a line had no full bank at line_start.

Function
REQ-012 SHALL hold two banks of LINE_W x PIX_W storage, each in one of the states EMPTY, FILLING or FULL; exactly one bank at a time is the fill bank, and the other is the display bank.
REQ-013 SHALL accept a write on a cycle with wr_valid and wr_ready both high, store it at fill bank address wr_ptr, and increment wr_ptr.
REQ-014 SHALL move the fill bank EMPTY->FILLING on the first accepted write, and FILLING->FULL on the write accepted at wr_ptr == LINE_W-1.
REQ-015 SHALL drive wr_ready = (fill bank state != FULL), as a registered signal.
REQ-016 SHALL evaluate line_start against the bank states registered at the start of that cycle; a final write accepted in the same cycle does not count toward the swap decision.
REQ-017 SHALL, on line_start with the fill bank FULL, swap roles; the new fill bank becomes EMPTY, wr_ptr becomes 0, rd_ptr becomes 0, and line_valid is set to 1.
REQ-018 SHALL, on line_start with the fill bank not FULL, not swap, set line_valid to 0, set underrun to 1, reset rd_ptr to 0, and leave the fill bank and wr_ptr unchanged.
REQ-019 SHALL read the display bank at rd_ptr on each pix_active cycle and increment rd_ptr, saturating at LINE_W-1.
REQ-020 SHALL have a latency of 1 cycle: rgb equals the display bank data at rd_ptr one cycle after a pix_active cycle with line_valid = 1; otherwise rgb = 0.
REQ-021 SHALL ignore wr_valid while wr_ready = 0; wr_data is a don't-care in that case.
REQ-022 SHALL clear underrun only by rst.

Reset
REQ-023 SHALL, on rst high at a clock edge, set both banks to EMPTY, bank 0 as fill bank, wr_ptr = 0, rd_ptr = 0, line_valid = 0, rgb = 0, underrun = 0 and wr_ready = 0; wr_ready becomes 1 on the first cycle after rst deasserts.
REQ-024 SHALL, on rst mid-line or mid-fill, discard all stored and partially written pixels; storage contents need not be cleared.

Configuration
REQ-025 SHALL, with VGA_LINE_BUF_UNDERRUN_COLOR_EN defined, drive rgb = 3'b100 (red) instead of 0 on pix_active-driven cycles of an underrun line, as a visible debug marker.
REQ-026 SHALL, without VGA_LINE_BUF_UNDERRUN_COLOR_EN, drive rgb = 0 on underrun lines; all other behaviour is identical.

Structure
REQ-027 SHALL take H_ACTIVE (640), V_ACTIVE (480), PIX_W (3), the bank state encoding (EMPTY, FILLING, FULL) and the colour constants (BLACK, RED) from the shared package vga_pkg.
REQ-028 SHALL implement each bank as sub-module vga_line_ram (1 write port, 1 synchronous read port, depth LINE_W), instantiated twice.

Verification
REQ-029 SHALL cover: write 640 pixels with value (i mod 8), then pulse line_start, then 640 pix_active cycles -> rgb sequence 0,1,...,7 repeating, starting 1 cycle after the first pix_active; underrun = 0.
REQ-030 SHALL cover: line_start with only 639 pixels written -> underrun = 1 and rgb = 0 for the whole line (rgb = 3'b100 with the macro defined); the 640th write then completes the bank and the next line displays it.
REQ-031 SHALL cover: fill both banks -> wr_ready = 0 after the 1280th accepted write; wr_valid held high for 10 cycles -> no pointer change; after line_start, wr_ready = 1 on the next cycle.
REQ-032 SHALL cover: line_start in the same cycle as the 640th write -> no swap and underrun = 1; the following line_start -> swap occurs and the line shows the data.
REQ-033 SHALL cover: rst asserted at pixel 300 of a displayed line -> rgb = 0 and wr_ready = 0 on the next cycle, underrun = 0, and a clean fill/display follows.
REQ-034 SHALL cover: wr_valid toggling 1-0-1 with random gaps over a 640-pixel fill -> the displayed line matches the written order exactly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants and types.
//   H_ACTIVE / V_ACTIVE : visible resolution
//   PIX_W               : bits per pixel (1 bit each of R, G, B)
//   bank_state_e        : occupancy state of one line-buffer bank
//   BLACK / RED         : colour constants used by the output stage
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIX_W    = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    localparam logic [PIX_W-1:0] BLACK = 3'b000;
    localparam logic [PIX_W-1:0] RED   = 3'b100;

endpackage

// File: rtl/vga_line_ram.sv
// One line-buffer bank: simple dual-port RAM, one write port and one
// synchronous read port (data appears the cycle after re_i).
// Ports:
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable
//   raddr_i  : read address
//   rdata_o  : registered read data
// Contents are never reset.
module vga_line_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 3,
    parameter int AW     = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_line_buffer.sv
// Double-buffered VGA line buffer. A producer fills one bank while the
// other bank is scanned out; banks swap roles at line_start when the fill
// bank holds a complete line. If it does not, the line is shown blank and
// the sticky underrun flag is raised.
// Ports:
//   clk25MHz   : pixel clock
//   rst        : synchronous active-high reset
//   line_start : one-cycle pulse in horizontal blanking before a visible line
//   pix_active : high for each active pixel cycle
//   wr_valid   : producer pixel valid
//   wr_data    : producer pixel (left to right)
//   wr_ready   : buffer can accept a pixel (registered)
//   rgb        : pixel to the display driver, one cycle after pix_active
//   underrun   : sticky, set when a line found no full bank at line_start
// Optional feature: define VGA_LINE_BUF_UNDERRUN_COLOR_EN to paint
// underrun lines red instead of black.
module vga_line_buffer #(
    parameter int LINE_W = vga_pkg::H_ACTIVE,
    parameter int PIX_W  = vga_pkg::PIX_W
) (
    input  logic             clk25MHz,
    input  logic             rst,
    input  logic             line_start,
    input  logic             pix_active,
    input  logic             wr_valid,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    output logic [PIX_W-1:0] rgb,
    output logic             underrun
);

    import vga_pkg::*;

    localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [AW-1:0] LAST = AW'(LINE_W - 1);

    bank_state_e    bank_q [2];
    bank_state_e    bank_d [2];
    logic           fill_sel_q,   fill_sel_d;
    logic [AW-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q,     rd_ptr_d;
    logic           line_valid_q, line_valid_d;
    logic           underrun_q,   underrun_d;
    logic           wr_ready_q,   wr_ready_d;
    logic           out_valid_q,  out_valid_d;
    logic           disp_sel_q,   disp_sel_d;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
    logic           line_ur_q,    line_ur_d;
    logic           out_red_q,    out_red_d;
`endif

    logic             wr_fire;
    logic             fill_full;
    logic [PIX_W-1:0] rdata0, rdata1;

    assign wr_fire   = wr_valid && wr_ready_q;
    // Swap decision uses the state registered at the start of the cycle,
    // so a final write landing in the same cycle does not qualify.
    assign fill_full = (bank_q[fill_sel_q] == FULL);

    always_comb begin
        bank_d       = bank_q;
        fill_sel_d   = fill_sel_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        line_valid_d = line_valid_q;
        underrun_d   = underrun_q;
        disp_sel_d   = ~fill_sel_q;
        out_valid_d  = pix_active && line_valid_q;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
        line_ur_d    = line_ur_q;
        out_red_d    = pix_active && line_ur_q;
`endif

        // Fill side. wr_ready_q is low whenever the fill bank is FULL, so a
        // write never coincides with a swap.
        if (wr_fire) begin
            if (wr_ptr_q == LAST) begin
                bank_d[fill_sel_q] = FULL;
                wr_ptr_d           = '0;
            end else begin
                bank_d[fill_sel_q] = FILLING;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
        end

        // Display side.
        if (line_start) begin
            rd_ptr_d = '0;
            if (fill_full) begin
                fill_sel_d          = ~fill_sel_q;
                bank_d[~fill_sel_q] = EMPTY;
                wr_ptr_d            = '0;
                line_valid_d        = 1'b1;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
                line_ur_d           = 1'b0;
`endif
            end else begin
                line_valid_d = 1'b0;
                underrun_d   = 1'b1;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
                line_ur_d    = 1'b1;
`endif
            end
        end else if (pix_active && (rd_ptr_q != LAST)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        wr_ready_d = (bank_d[fill_sel_d] != FULL);
    end

    always_ff @(posedge clk25MHz) begin
        if (rst) begin
            bank_q[0]    <= EMPTY;
            bank_q[1]    <= EMPTY;
            fill_sel_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            line_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            wr_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
            line_ur_q    <= 1'b0;
            out_red_q    <= 1'b0;
`endif
        end else begin
            bank_q       <= bank_d;
            fill_sel_q   <= fill_sel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            line_valid_q <= line_valid_d;
            underrun_q   <= underrun_d;
            wr_ready_q   <= wr_ready_d;
            out_valid_q  <= out_valid_d;
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
            line_ur_q    <= line_ur_d;
            out_red_q    <= out_red_d;
`endif
        end
        // Bank select travels with the RAM read; it is qualified by
        // out_valid_q so it needs no reset.
        disp_sel_q <= disp_sel_d;
    end

    vga_line_ram #(
        .DEPTH  (LINE_W),
        .DATA_W (PIX_W),
        .AW     (AW)
    ) u_bank0 (
        .clk_i   (clk25MHz),
        .we_i    (wr_fire && !fill_sel_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (pix_active),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata0)
    );

    vga_line_ram #(
        .DEPTH  (LINE_W),
        .DATA_W (PIX_W),
        .AW     (AW)
    ) u_bank1 (
        .clk_i   (clk25MHz),
        .we_i    (wr_fire && fill_sel_q),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (pix_active),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata1)
    );

    // Output stage: RAM data is already registered; only the qualifying
    // mux follows it.
    always_comb begin
        rgb = PIX_W'(BLACK);
        if (out_valid_q) begin
            rgb = disp_sel_q ? rdata1 : rdata0;
        end
`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
        else if (out_red_q) begin
            rgb = PIX_W'(RED);
        end
`endif
    end

    assign wr_ready = wr_ready_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_buffer.sv
module tb_vga_line_buffer;

    localparam int LW = 640;

`ifdef VGA_LINE_BUF_UNDERRUN_COLOR_EN
    localparam logic [2:0] UR_COLOR = 3'b100;
`else
    localparam logic [2:0] UR_COLOR = 3'b000;
`endif

    logic       clk25MHz = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic       pix_active = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_data = '0;
    logic       wr_ready;
    logic [2:0] rgb;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    logic [2:0] line_exp [LW];
    logic [2:0] sb [$];

    vga_line_buffer #(.LINE_W(LW), .PIX_W(3)) dut (
        .clk25MHz   (clk25MHz),
        .rst        (rst),
        .line_start (line_start),
        .pix_active (pix_active),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rgb        (rgb),
        .underrun   (underrun)
    );

    always #20 clk25MHz = ~clk25MHz;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted write; waits (bounded) for wr_ready first.
    task automatic write_px(input logic [2:0] d);
        int w = 0;
        while (!wr_ready && w < 50) begin
            tick();
            w++;
        end
        if (w == 50) check("wr_ready_wait", wr_ready, 1);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Two blanking cycles, then n active pixels through the scoreboard.
    task automatic show_line(input bit valid, input int n, input string tag);
        logic [2:0] e;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            pix_active = 1'b1;
            sb.push_back(valid ? line_exp[i] : UR_COLOR);
            tick();
            e = sb.pop_front();
            check(tag, rgb, e);
        end
        if (n == LW) begin
            pix_active = 1'b0;
            tick();
            check({tag, "_tail"}, rgb, 0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_rgb", rgb, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        tick();
        check("post_rst_wr_ready", wr_ready, 1);

        // Basic line: pixel i = i mod 8
        for (int i = 0; i < LW; i++) begin
            line_exp[i] = 3'(i % 8);
            write_px(line_exp[i]);
        end
        check("full0_wr_ready", wr_ready, 0);
        pulse_line_start();
        check("swap0_wr_ready", wr_ready, 1);
        show_line(1'b1, LW, "line_mod8");
        check("line_mod8_underrun", underrun, 0);

        // Second bank fills to 1280 total writes; held wr_valid is ignored
        for (int i = 0; i < LW; i++) begin
            line_exp[i] = 3'((3 * i + 1) % 8);
            write_px(line_exp[i]);
        end
        check("full1_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 3'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_wr_ready", wr_ready, 0);
        end
        wr_valid = 1'b0;
        pulse_line_start();
        check("swap1_wr_ready", wr_ready, 1);
        show_line(1'b1, LW, "line_3i1");

        // Underrun with 639 pixels, then completion shows next line
        for (int i = 0; i < LW - 1; i++) begin
            write_px(3'((i + 5) % 8));
        end
        pulse_line_start();
        check("ur_flag", underrun, 1);
        show_line(1'b0, LW, "ur_line");
        write_px(3'((LW - 1 + 5) % 8));
        check("ur_complete_wr_ready", wr_ready, 0);
        for (int i = 0; i < LW; i++) line_exp[i] = 3'((i + 5) % 8);
        pulse_line_start();
        check("ur_sticky", underrun, 1);
        show_line(1'b1, 300, "after_ur");

        // Reset at pixel 300
        rst = 1'b1;
        pix_active = 1'b1;
        tick();
        check("midrst_rgb", rgb, 0);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_underrun", underrun, 0);
        rst = 1'b0;
        pix_active = 1'b0;
        tick();
        check("midrst_wr_ready_back", wr_ready, 1);

        // Fill with random gaps and random data
        for (int i = 0; i < LW; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
            line_exp[i] = 3'($urandom_range(0, 7));
            write_px(line_exp[i]);
        end
        pulse_line_start();
        show_line(1'b1, LW, "gap_line");
        check("gap_underrun", underrun, 0);

        // line_start in the same cycle as the 640th write
        for (int i = 0; i < LW; i++) line_exp[i] = 3'(7 - (i % 8));
        for (int i = 0; i < LW - 1; i++) write_px(line_exp[i]);
        wr_valid   = 1'b1;
        wr_data    = line_exp[LW-1];
        line_start = 1'b1;
        tick();
        wr_valid   = 1'b0;
        line_start = 1'b0;
        check("race_underrun", underrun, 1);
        check("race_wr_ready", wr_ready, 0);
        show_line(1'b0, LW, "race_blank");
        pulse_line_start();
        check("race_swap_wr_ready", wr_ready, 1);
        show_line(1'b1, LW, "race_line");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
